// File: rtl/dllp_tx_scheduler.sv
// dllp_tx_scheduler: picks the next DLLP (InitFC1/InitFC2 triplets, Ack, Nak,
// UpdateFC) and presents it to the DLLP creator through a registered
// valid/ready slot.
// Optional build macro: DLLP_STARVE_GUARD_EN adds an UpdateFC starvation guard
// (parameter STARVE_MAX) on top of the strict Nak > Ack > UpdateFC priority.
module dllp_tx_scheduler #(
  parameter int unsigned INIT_GAP = 64
`ifdef DLLP_STARVE_GUARD_EN
  , parameter int unsigned STARVE_MAX = 8
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dl_down,
  input  logic        start_fc_init1,
  input  logic        start_fc_init2,
  input  logic        run_time_on,
  input  logic        initiate_ack,
  input  logic        initiate_nak,
  input  logic [11:0] pending_seq_num,
  input  logic        transmit_update_dllp,
  input  logic [7:0]  ph_credits,
  input  logic [7:0]  nph_credits,
  input  logic [7:0]  ch_credits,
  input  logic [11:0] pd_credits,
  input  logic [11:0] npd_credits,
  input  logic [11:0] cd_credits,
  input  logic        dllp_rdy,
  output logic        dllp_vld,
  output logic [7:0]  dllp_type,
  output logic [11:0] dllp_seq,
  output logic [7:0]  dllp_hdr_fc,
  output logic [11:0] dllp_data_fc,
  output logic        init_round_done,
  output logic        ack_nak_pend
);

  localparam int unsigned GAP_W = $clog2(INIT_GAP + 1);
  localparam logic [7:0] T_ACK    = 8'h00;
  localparam logic [7:0] T_NAK    = 8'h10;
  localparam logic [7:0] T_IFC1_C = 8'h60;
  localparam logic [7:0] T_IFC2_C = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_INIT1, S_INIT2, S_RUN} state_t;

  state_t           state_q, mode_c;
  logic             vld_q, irdone_q, anp_q;
  logic [7:0]       type_q, hdr_q;
  logic [11:0]      seq_out_q, data_q;
  logic             ack_q, nak_q, ack_d, nak_d;
  logic [11:0]      seq_q, seq_d;
  logic [2:0]       upd_q, upd_d;
  logic [1:0]       idx_q, rr_q;
  logic             gap_act_q;
  logic [GAP_W-1:0] gap_q;

  logic        slot_free, c_accept, gap_open, enter_init, nxt_an;
  logic        upd_hit, upd_first, take_upd;
  logic [1:0]  upd_pick;
  logic        sel_vld, sel_cred, adv_idx, g_ack, g_nak;
  logic [2:0]  g_upd;
  logic [1:0]  sel_cls;
  logic [7:0]  sel_type, sel_hdr;
  logic [11:0] sel_seq, sel_data;

  assign dllp_vld        = vld_q;
  assign dllp_type       = type_q;
  assign dllp_seq        = seq_out_q;
  assign dllp_hdr_fc     = hdr_q;
  assign dllp_data_fc    = data_q;
  assign init_round_done = irdone_q;
  assign ack_nak_pend    = anp_q;

  assign slot_free  = !vld_q || dllp_rdy;
  assign c_accept   = vld_q && dllp_rdy && (type_q == T_IFC1_C || type_q == T_IFC2_C);
  assign gap_open   = !gap_act_q || (gap_q == GAP_W'(INIT_GAP - 1));
  assign enter_init = (mode_c == S_INIT1 || mode_c == S_INIT2) && (mode_c != state_q);
  assign upd_hit    = |upd_q;

`ifdef DLLP_STARVE_GUARD_EN
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
  logic [STV_W-1:0] stv_q;
  assign upd_first = (stv_q >= STV_W'(STARVE_MAX));

  // Count Ack/Nak grants that bypass a waiting UpdateFC; cleared by an UpdateFC grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            stv_q <= '0;
    else if (dl_down || (|g_upd))                       stv_q <= '0;
    else if ((g_ack || g_nak) && upd_hit && !upd_first) stv_q <= stv_q + STV_W'(1);
  end
`else
  assign upd_first = 1'b0;
`endif

  assign take_upd = upd_hit && (upd_first || (!nak_q && !ack_q));

  // Mode decode with dl_down highest priority
  always_comb begin
    mode_c = S_IDLE;
    if (dl_down)             mode_c = S_IDLE;
    else if (start_fc_init1) mode_c = S_INIT1;
    else if (start_fc_init2) mode_c = S_INIT2;
    else if (run_time_on)    mode_c = S_RUN;
  end

  // Round-robin pick among set UpdateFC bits starting at the pointer
  always_comb begin
    upd_pick = rr_q;
    for (int k = 2; k >= 0; k--) begin
      if (upd_q[(int'(rr_q) + k) % 3]) upd_pick = 2'((int'(rr_q) + k) % 3);
    end
  end

  // Next-slot selection and grants
  always_comb begin
    sel_vld  = 1'b0;
    sel_type = '0;
    sel_seq  = '0;
    sel_hdr  = '0;
    sel_data = '0;
    sel_cls  = 2'd0;
    sel_cred = 1'b0;
    adv_idx  = 1'b0;
    g_ack    = 1'b0;
    g_nak    = 1'b0;
    g_upd    = '0;
    if (slot_free && !dl_down) begin
      case (state_q)
        S_INIT1, S_INIT2: begin
          if (gap_open && !c_accept) begin
            sel_vld  = 1'b1;
            sel_type = ((state_q == S_INIT1) ? 8'h40 : 8'hC0) | {2'b00, idx_q, 4'h0};
            sel_cls  = idx_q;
            sel_cred = 1'b1;
            adv_idx  = 1'b1;
          end
        end
        S_RUN: begin
          if (take_upd) begin
            sel_vld         = 1'b1;
            sel_type        = 8'h80 | {2'b00, upd_pick, 4'h0};
            sel_cls         = upd_pick;
            sel_cred        = 1'b1;
            g_upd[upd_pick] = 1'b1;
          end else if (nak_q) begin
            sel_vld  = 1'b1;
            sel_type = T_NAK;
            sel_seq  = seq_q;
            g_nak    = 1'b1;
          end else if (ack_q) begin
            sel_vld  = 1'b1;
            sel_type = T_ACK;
            sel_seq  = seq_q;
            g_ack    = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (sel_cred) begin
      case (sel_cls)
        2'd0:    begin sel_hdr = ph_credits;  sel_data = pd_credits;  end
        2'd1:    begin sel_hdr = nph_credits; sel_data = npd_credits; end
        default: begin sel_hdr = ch_credits;  sel_data = cd_credits;  end
      endcase
    end
  end

  // Pending request bookkeeping: Nak supersedes Ack, repeats overwrite seq
  always_comb begin
    ack_d = ack_q & ~g_ack;
    nak_d = nak_q & ~g_nak;
    seq_d = seq_q;
    if (state_q == S_RUN) begin
      if (initiate_nak) begin
        nak_d = 1'b1;
        ack_d = 1'b0;
        seq_d = pending_seq_num;
      end else if (initiate_ack && !nak_d) begin
        ack_d = 1'b1;
        seq_d = pending_seq_num;
      end
    end
    upd_d = (upd_q & ~g_upd) | ({3{transmit_update_dllp}} & ~upd_q);
  end

  assign nxt_an = slot_free ? (sel_vld && (sel_type == T_ACK || sel_type == T_NAK))
                            : (vld_q && (type_q == T_ACK || type_q == T_NAK));

  // State, output slot, pending bits, triplet index, gap counter, RR pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vld_q     <= 1'b0;
      type_q    <= '0;
      seq_out_q <= '0;
      hdr_q     <= '0;
      data_q    <= '0;
      irdone_q  <= 1'b0;
      anp_q     <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      seq_q     <= '0;
      upd_q     <= '0;
      idx_q     <= '0;
      rr_q      <= '0;
      gap_act_q <= 1'b0;
      gap_q     <= '0;
    end else if (dl_down) begin
      state_q   <= S_IDLE;
      vld_q     <= 1'b0;
      type_q    <= '0;
      seq_out_q <= '0;
      hdr_q     <= '0;
      data_q    <= '0;
      irdone_q  <= 1'b0;
      anp_q     <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      seq_q     <= '0;
      upd_q     <= '0;
      idx_q     <= '0;
      rr_q      <= '0;
      gap_act_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q  <= mode_c;
      irdone_q <= c_accept;
      anp_q    <= ack_d || nak_d || nxt_an;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
      seq_q    <= seq_d;
      upd_q    <= upd_d;
      if (slot_free) begin
        vld_q     <= sel_vld;
        type_q    <= sel_type;
        seq_out_q <= sel_seq;
        hdr_q     <= sel_hdr;
        data_q    <= sel_data;
      end
      if (|g_upd) rr_q <= (upd_pick == 2'd2) ? 2'd0 : upd_pick + 2'd1;
      if (enter_init) begin
        idx_q     <= '0;
        gap_act_q <= 1'b0;
        gap_q     <= '0;
      end else begin
        if (adv_idx) idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        if (c_accept) begin
          gap_act_q <= 1'b1;
          gap_q     <= '0;
        end else if (gap_act_q) begin
          if (gap_q == GAP_W'(INIT_GAP - 1)) begin
            gap_act_q <= 1'b0;
            gap_q     <= '0;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
      end
    end
  end

endmodule
